// File: rtl/soc_apb_timer_event_gen.sv
// Trigger conditioner in front of the APB timer. Each timer half selects one external line,
// which is synchronised, glitch-filtered and edge-detected into a registered event pulse.
module soc_apb_timer_event_gen #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned N_EXT          = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
    input  logic [31:0]               PWDATA_i,
    input  logic                      PWRITE_i,
    input  logic                      PSEL_i,
    input  logic                      PENABLE_i,
    output logic [31:0]               PRDATA_o,
    output logic                      PREADY_o,
    output logic                      PSLVERR_o,
    input  logic [N_EXT-1:0]          ext_trig_i,
    output logic                      event_lo_o,
    output logic                      event_hi_o
);
    typedef enum logic [1:0] {MODE_RISE, MODE_FALL, MODE_BOTH, MODE_LEVEL} mode_e;

    typedef struct packed {
        logic       en;
        logic [3:0] filt;
        mode_e      mode;
        logic [7:0] sel;
    } cfg_t;

    cfg_t [1:0]       cfg_q, cfg_d;
    logic [N_EXT-1:0] sync1_q, sync2_q;
    logic [1:0]       filt_q, filt_d, prev_q, prev_d;
    logic [1:0][3:0]  fcnt_q, fcnt_d;
    logic [1:0]       mux, det, hit;
    logic [1:0]       event_q;
    logic [1:0]       status_q, status_d;
    logic [15:0]      evt_lo_q, evt_lo_d, evt_hi_q, evt_hi_d;
    logic             wr_en, rd_en, status_wr, evt_wr;
    logic [1:0]       cfg_wr;
    logic [3:0]       off;
    cfg_t             wcfg;
    logic             unused_bits;

    // Zero-wait-state APB: an access completes in the cycle PSEL & PENABLE are both high,
    // so writes commit on that edge and read data is only driven during that cycle.
    assign wr_en     = PSEL_i & PENABLE_i & PWRITE_i;
    assign rd_en     = PSEL_i & PENABLE_i & ~PWRITE_i;
    assign off       = PADDR_i[3:0];
    assign cfg_wr[0] = wr_en && (off == 4'h0);
    assign cfg_wr[1] = wr_en && (off == 4'h4);
    assign status_wr = wr_en && (off == 4'h8);
    assign evt_wr    = wr_en && (off == 4'hC);
    assign wcfg      = cfg_t'({PWDATA_i[16], PWDATA_i[15:12], PWDATA_i[9:8], PWDATA_i[7:0]});

    assign PREADY_o    = 1'b1;
    assign PSLVERR_o   = 1'b0;
    assign event_lo_o  = event_q[0];
    assign event_hi_o  = event_q[1];
    assign unused_bits = ^{PADDR_i[APB_ADDR_WIDTH-1:4], PWDATA_i[31:18], PWDATA_i[11:10]};

    function automatic logic pick(input logic [N_EXT-1:0] v, input logic [7:0] sel);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(N_EXT); i++) begin
            if (sel == 8'(i)) r = v[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] cfg_rd(input cfg_t c);
        return {15'b0, c.en, c.filt, 2'b00, c.mode, c.sel};
    endfunction

    always_comb begin
        cfg_d  = cfg_q;
        filt_d = filt_q;
        prev_d = filt_q;
        fcnt_d = fcnt_q;
        mux    = '0;
        det    = '0;
        hit    = '0;
        for (int c = 0; c < 2; c++) begin
            mux[c] = pick(sync2_q, cfg_q[c].sel);
            case (cfg_q[c].mode)
                MODE_RISE: det[c] = filt_q[c] & ~prev_q[c];
                MODE_FALL: det[c] = ~filt_q[c] & prev_q[c];
                MODE_BOTH: det[c] = filt_q[c] ^ prev_q[c];
                default:   det[c] = filt_q[c];
            endcase
            if (cfg_wr[c]) begin
                // Re-seed from the new source so a select or enable change cannot look like an edge.
                cfg_d[c]  = wcfg;
                filt_d[c] = pick(sync2_q, wcfg.sel);
                prev_d[c] = pick(sync2_q, wcfg.sel);
                fcnt_d[c] = '0;
                hit[c]    = wcfg.en & PWDATA_i[17];
            end else begin
                hit[c] = cfg_q[c].en & det[c];
                if (mux[c] == filt_q[c]) begin
                    fcnt_d[c] = '0;
                end else if (fcnt_q[c] == cfg_q[c].filt) begin
                    filt_d[c] = mux[c];
                    fcnt_d[c] = '0;
                end else begin
                    fcnt_d[c] = fcnt_q[c] + 4'd1;
                end
            end
        end
    end

    // A pulse landing on the same edge as a clear wins for STATUS but loses for EVT_CNT.
    assign status_d = (status_q & ~(status_wr ? PWDATA_i[1:0] : 2'b00)) | event_q;
    assign evt_lo_d = evt_wr ? 16'h0 : evt_lo_q + {15'b0, event_q[0]};
    assign evt_hi_d = evt_wr ? 16'h0 : evt_hi_q + {15'b0, event_q[1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            prev_q   <= '0;
            fcnt_q   <= '0;
            event_q  <= '0;
            status_q <= '0;
            evt_lo_q <= '0;
            evt_hi_q <= '0;
        end else begin
            cfg_q    <= cfg_d;
            sync1_q  <= ext_trig_i;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            prev_q   <= prev_d;
            fcnt_q   <= fcnt_d;
            event_q  <= hit;
            status_q <= status_d;
            evt_lo_q <= evt_lo_d;
            evt_hi_q <= evt_hi_d;
        end
    end

    always_comb begin
        PRDATA_o = '0;
        if (rd_en) begin
            case (off)
                4'h0:    PRDATA_o = cfg_rd(cfg_q[0]);
                4'h4:    PRDATA_o = cfg_rd(cfg_q[1]);
                4'h8:    PRDATA_o = {30'b0, status_q};
                4'hC:    PRDATA_o = {evt_hi_q, evt_lo_q};
                default: PRDATA_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_apb_timer_event_gen.sv
// Directed and randomized checks of soc_apb_timer_event_gen against a window-based filter model.
module tb_soc_apb_timer_event_gen;
    localparam int N_EXT = 8;
    localparam int M     = 16383;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] PADDR_i = '0;
    logic [31:0] PWDATA_i = '0;
    logic        PWRITE_i = 1'b0, PSEL_i = 1'b0, PENABLE_i = 1'b0;
    logic [31:0] PRDATA_o;
    logic        PREADY_o, PSLVERR_o;
    logic [N_EXT-1:0] ext_trig = '0;
    logic        event_lo_o, event_hi_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;
    logic [N_EXT-1:0] hist [0:M];
    logic             fm   [0:M];
    logic [31:0]      rd;

    soc_apb_timer_event_gen #(.APB_ADDR_WIDTH(12), .N_EXT(N_EXT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .PADDR_i(PADDR_i), .PWDATA_i(PWDATA_i),
        .PWRITE_i(PWRITE_i), .PSEL_i(PSEL_i), .PENABLE_i(PENABLE_i), .PRDATA_o(PRDATA_o),
        .PREADY_o(PREADY_o), .PSLVERR_o(PSLVERR_o), .ext_trig_i(ext_trig),
        .event_lo_o(event_lo_o), .event_hi_o(event_hi_o)
    );

    always #5 clk_i = ~clk_i;

    // Pin value sampled at each rising edge, indexed by edge number.
    always @(posedge clk_i) begin
        hist[ecnt & M] <= ext_trig;
        ecnt <= ecnt + 1;
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        PSEL_i = 1'b1; PWRITE_i = 1'b1; PENABLE_i = 1'b0;
        PADDR_i = {8'h0, addr}; PWDATA_i = data;
        cyc();
        PENABLE_i = 1'b1;
        cyc();
        PSEL_i = 1'b0; PENABLE_i = 1'b0; PWRITE_i = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
        PSEL_i = 1'b1; PWRITE_i = 1'b0; PENABLE_i = 1'b0; PADDR_i = {8'h0, addr};
        cyc();
        PENABLE_i = 1'b1;
        #1 data = PRDATA_o;
        cyc();
        PSEL_i = 1'b0; PENABLE_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        check(tag, d, exp);
    endtask

    // Drive one line to val for hold sampled edges, then invert; check both events every cycle.
    task automatic pulse_check(input string tag, input int line, input logic val, input int hold,
                               input int total, input logic [31:0] lo_exp, input logic [31:0] hi_exp);
        ext_trig[line] = val;
        for (int i = 0; i < total; i++) begin
            cyc();
            if (i == hold - 1) ext_trig[line] = ~val;
            check({tag, "_lo"}, {31'b0, event_lo_o}, {31'b0, lo_exp[i]});
            check({tag, "_hi"}, {31'b0, event_hi_o}, {31'b0, hi_exp[i]});
        end
    endtask

    // Sample seen by the filter at edge j: the pin value taken two edges earlier.
    function automatic logic samp(input int j, input logic [7:0] sel);
        logic [N_EXT-1:0] h;
        h = hist[(j - 2) & M];
        if (sel < 8'(N_EXT)) return h[sel[2:0]];
        return 1'b0;
    endfunction

    function automatic logic ev(input logic [1:0] mode, input logic cur, input logic prv);
        case (mode)
            2'd0:    return cur && !prv;
            2'd1:    return !cur && prv;
            2'd2:    return cur != prv;
            default: return cur;
        endcase
    endfunction

    task automatic rand_round();
        logic [7:0]  sel;
        logic [1:0]  mode;
        logic [3:0]  f;
        logic [31:0] cfgw;
        logic        v, same, exp_e;
        int          n, k, exp_cnt;
        sel  = 8'($urandom_range(0, 9));
        mode = 2'($urandom_range(0, 3));
        f    = 4'($urandom_range(0, 4));
        cfgw = {15'b0, 1'b1, f, 2'b00, mode, sel};
        apb_write(4'hC, 32'h0);
        apb_write(4'h4, cfgw);
        n = ecnt - 1;
        fm[n & M]       = samp(n, sel);
        fm[(n - 1) & M] = fm[n & M];
        exp_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            if (i >= 60) ext_trig = '0;
            else if ($urandom_range(0, 2) == 0) ext_trig = 8'($urandom);
            cyc();
            k = ecnt - 1;
            // The filter output follows a level once the last F+1 samples all agree on it.
            v = samp(k, sel);
            same = (k - int'(f) >= n);
            if (same) begin
                for (int j = k - int'(f); j <= k; j++) if (samp(j, sel) != v) same = 1'b0;
            end
            fm[k & M] = same ? v : fm[(k - 1) & M];
            exp_e = ev(mode, fm[(k - 1) & M], fm[(k - 2) & M]);
            if (exp_e) exp_cnt++;
            check("rnd_evt_hi", {31'b0, event_hi_o}, {31'b0, exp_e});
            check("rnd_evt_lo", {31'b0, event_lo_o}, 32'h0);
        end
        read_check("rnd_cnt", 4'hC, {16'(exp_cnt), 16'h0});
        read_check("rnd_cfg", 4'h4, cfgw);
    endtask

    initial begin
        // Reset and defaults
        rst_i = 1'b1;
        cyc(); cyc();
        check("rst_evt_lo", {31'b0, event_lo_o}, 32'h0);
        check("rst_evt_hi", {31'b0, event_hi_o}, 32'h0);
        rst_i = 1'b0;
        check("pready", {31'b0, PREADY_o}, 32'h1);
        check("pslverr", {31'b0, PSLVERR_o}, 32'h0);
        read_check("rst_cfg_lo", 4'h0, 32'h0);
        read_check("rst_cfg_hi", 4'h4, 32'h0);
        read_check("rst_status", 4'h8, 32'h0);
        read_check("rst_evtcnt", 4'hC, 32'h0);
        ext_trig = 8'hFF;
        pulse_check("dis_hi", 0, 1'b1, 99, 6, 32'h0, 32'h0);
        ext_trig = 8'h00;
        pulse_check("dis_lo", 0, 1'b0, 99, 6, 32'h0, 32'h0);
        apb_write(4'h2, 32'hFFFF_FFFF);
        read_check("unmapped_rd", 4'h2, 32'h0);
        read_check("unmapped_cfg", 4'h0, 32'h0);

        // Rising edge, F=0, on line 3
        apb_write(4'h0, 32'h0001_0003);
        read_check("cfg_lo_rb", 4'h0, 32'h0001_0003);
        pulse_check("rise", 3, 1'b1, 99, 8, 32'h8, 32'h0);
        read_check("rise_status", 4'h8, 32'h1);
        read_check("rise_cnt", 4'hC, 32'h1);
        pulse_check("fall_ign", 3, 1'b0, 99, 8, 32'h0, 32'h0);
        read_check("fall_cnt", 4'hC, 32'h1);
        PSEL_i = 1'b1; PWRITE_i = 1'b0; PENABLE_i = 1'b0; PADDR_i = 12'hC;
        #1 check("rd_gate", PRDATA_o, 32'h0);
        PSEL_i = 1'b0;

        // Glitch filter, F=2, both edges, line 1 on hi
        apb_write(4'h8, 32'h3);
        apb_write(4'hC, 32'h0);
        apb_write(4'h4, 32'h0001_2201);
        pulse_check("glitch2", 1, 1'b1, 2, 12, 32'h0, 32'h0);
        pulse_check("glitch3", 1, 1'b1, 3, 14, 32'h0, 32'h120);
        read_check("glitch_cnt", 4'hC, 32'h0002_0000);
        read_check("glitch_status", 4'h8, 32'h2);

        // Software trigger with resync onto a line that is already high
        ext_trig[5] = 1'b1;
        cyc(); cyc(); cyc();
        apb_write(4'hC, 32'h0);
        apb_write(4'h0, 32'h0003_0005);
        check("sw_pulse", {31'b0, event_lo_o}, 32'h1);
        pulse_check("sw_after", 5, 1'b1, 99, 6, 32'h0, 32'h0);
        read_check("sw_cfg_rb", 4'h0, 32'h0001_0005);
        read_check("sw_cnt", 4'hC, 32'h1);
        apb_write(4'h0, 32'h0002_0005);
        check("sw_dis", {31'b0, event_lo_o}, 32'h0);
        pulse_check("sw_dis_after", 5, 1'b1, 99, 4, 32'h0, 32'h0);
        read_check("sw_dis_cnt", 4'hC, 32'h1);

        // STATUS W1C racing a pulse: set wins
        apb_write(4'h0, 32'h0001_0003);
        apb_write(4'h8, 32'h3);
        read_check("st_cleared", 4'h8, 32'h0);
        ext_trig[3] = 1'b1;
        cyc(); cyc(); cyc();
        apb_write(4'h8, 32'h1);
        read_check("w1c_race", 4'h8, 32'h1);
        apb_write(4'h8, 32'h1);
        read_check("w1c_clear", 4'h8, 32'h0);

        // EVT_CNT clear racing a pulse: clear wins
        ext_trig[3] = 1'b0;
        repeat (6) cyc();
        ext_trig[3] = 1'b1;
        cyc(); cyc(); cyc();
        apb_write(4'hC, 32'h0);
        read_check("cnt_clr_race", 4'hC, 32'h0);

        // Level mode on line 2 for 10 samples
        ext_trig = '0;
        apb_write(4'h0, 32'h0001_0302);
        repeat (4) cyc();
        apb_write(4'hC, 32'h0);
        pulse_check("level", 2, 1'b1, 10, 20, 32'h1FF8, 32'h0);
        read_check("level_cnt", 4'hC, 32'd10);

        // Out-of-range select only fires from software
        apb_write(4'h0, 32'h0001_02FF);
        apb_write(4'hC, 32'h0);
        pulse_check("badsel0", 0, 1'b1, 4, 10, 32'h0, 32'h0);
        pulse_check("badsel7", 7, 1'b1, 4, 10, 32'h0, 32'h0);
        read_check("badsel_cnt", 4'hC, 32'h0);
        apb_write(4'h0, 32'h0003_02FF);
        check("badsel_sw", {31'b0, event_lo_o}, 32'h1);
        cyc();
        check("badsel_sw_end", {31'b0, event_lo_o}, 32'h0);
        read_check("badsel_sw_cnt", 4'hC, 32'h1);

        // Randomized configurations on hi against the reference model
        ext_trig = '0;
        apb_write(4'h0, 32'h0);
        apb_write(4'h4, 32'h0);
        repeat (8) cyc();
        repeat (6) rand_round();

        // Lo counter wrap: 0xFFFF level events, then one software event
        ext_trig = 8'h08;
        repeat (4) cyc();
        apb_write(4'hC, 32'h0);
        apb_write(4'h0, 32'h0001_0303);
        repeat (65534) cyc();
        apb_write(4'h0, 32'h0000_0303);
        read_check("preload_cnt", 4'hC, 32'h0000_FFFF);
        apb_write(4'h0, 32'h0003_00FF);
        read_check("wrap_cnt", 4'hC, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/soc_apb_timer_event_gen.md
# soc_apb_timer_event_gen

APB-configured trigger conditioner sitting directly upstream of the SoC APB timer. It selects one of `N_EXT` asynchronous external trigger lines per timer half, then synchronises, glitch-filters and edge-detects it. It emits single-cycle (or level) pulses on `event_lo_o`/`event_hi_o`, which drive the timer's `event_lo_i`/`event_hi_i` start inputs. It also provides a software trigger, sticky event status and per-channel event counters.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width; only `PADDR_i[3:0]` decoded
- `N_EXT`, 8, number of external trigger lines (1..256)
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; **one clock; reset is synchronous and active-high**
- `PADDR_i`  in  APB_ADDR_WIDTH  APB address
- `PWDATA_i`  in  32  write data
- `PWRITE_i`, `PSEL_i`, `PENABLE_i`  in  1  APB control
- `PRDATA_o`  out  32  read data
- `PREADY_o`  out  1  constant 1
- `PSLVERR_o`  out  1  constant 0
- `ext_trig_i`  in  N_EXT  asynchronous external triggers
- `event_lo_o`, `event_hi_o`  out  1  registered event pulses to timer lo/hi

## Operation
**Registers** (offset `PADDR_i[3:0]`; unmapped offsets read 0 and ignore writes):
- 0x0 `CFG_LO`, 0x4 `CFG_HI`, one per channel:
  - [7:0] `SEL`: source index; `SEL >= N_EXT` gives constant 0
  - [9:8] `MODE`: 00 rising, 01 falling, 10 both edges, 11 level-high
  - [15:12] `FILT` = F
  - [16] `EN`
  - [17] `SWTRIG`: write-1 pulse, always reads 0
  - other bits read 0
- 0x8 `STATUS`: [0] lo sticky, [1] hi sticky; write-1-to-clear.
- 0xC `EVT_CNT`: [15:0] lo count, [31:16] hi count, both wrapping mod 2^16. Any write clears both.

**APB protocol**
- A write commits on the clock edge where `PSEL_i & PENABLE_i & PWRITE_i`.
- `PRDATA_o` is 0 unless `PSEL_i & PENABLE_i & !PWRITE_i`.
- Zero wait states.

**Datapath**
- Every `ext_trig_i` bit passes through a 2-flop synchroniser (`sync2`). The per-channel mux selects from the `sync2` outputs.
- Per-channel filter: state `filt` plus a 4-bit counter `cnt`.
  - Mux output ≠ `filt`: if `cnt == F`, load `filt` and clear `cnt`; else increment `cnt`.
  - Mux output == `filt`: clear `cnt`.
  - A level must therefore be stable for F+1 consecutive `sync2` samples to pass.
- Edge detect compares `filt` with `filt_q` (previous cycle).
- `hit` = `EN` and one of:
  - the selected edge occurred, or `MODE` = 11 and `filt` = 1;
  - a `SWTRIG` write to this channel this cycle.
- `event_*_o` <= `hit`.
- On each registered pulse: set the channel's `STATUS` bit and increment its counter.

**CFG write resynchronisation**
- Any write to `CFG_x` loads `filt` and `filt_q` with the current `sync2` value of the newly written `SEL`, and clears `cnt`.
- Edge detection is suppressed that cycle, so changing the source or enabling never produces a spurious edge.
- A `SWTRIG`=1 in the same write still fires, provided the written `EN`=1.

**Boundary rules**
- `STATUS`: set and W1C in the same cycle → set wins.
- `EVT_CNT`: clear and increment in the same cycle → clear wins (result 0).
- Counter wrap: 0xFFFF + 1 = 0x0000, with no flag.
- `EN`=0: no events, filter keeps tracking.
- Level mode: pulse every cycle while `filt`=1 and `EN`=1, with one count per cycle.

**Reset** (`rst_i` high at an edge): all registers, sync flops, `filt`/`filt_q`/`cnt` go to 0, and `event_lo_o`/`event_hi_o` = 0. Reset asserted mid-filter discards the partial count.

## Timing
- An `ext_trig_i` change first sampled at edge n appears:
  - in `sync2` after edge n+1;
  - in `filt` after edge n+2+F;
  - on `event_*_o` after edge n+3+F.
- With F=0, pin-to-pulse latency is 3 cycles.
- A `SWTRIG` write committing at edge n drives `event_*_o` high for exactly the cycle after edge n.
- Edge-mode pulses are exactly 1 cycle wide.
- Successive edges separated by ≥F+1 cycles each produce a pulse.
- `STATUS`/`EVT_CNT` reflect a pulse on the edge after `event_*_o` rises. A read in the same cycle as the pulse returns the old value.
- Reads are combinational from registered state.

## Test plan
- **Reset and defaults:** `rst_i` high 2 cycles → all four registers read 0 and `event_*_o`=0. Then toggle `ext_trig_i` → no event, since `EN`=0.
- **Rising edge, F=0:** write `CFG_LO`=0x0001_0003 (SEL 3, rising, EN). Raise `ext_trig_i[3]`, first sampled at edge n → `event_lo_o`=1 only in the cycle after edge n+3. Then `STATUS`=0x1 and `EVT_CNT`=0x0000_0001. Falling edge → no pulse.
- **Glitch filter:** `CFG_HI`=0x0001_2201 (SEL 1, both edges, F=2, EN).
  - 2-cycle high pulse on `ext_trig_i[1]` → no event.
  - 3-cycle pulse → 2 events (rise, fall), each lagging its pin edge by 5 cycles.
  - `EVT_CNT`=0x0002_0000.
- **Software trigger and resync:**
  - `ext_trig_i[5]`=1 held. Write `CFG_LO`=0x0003_0005 → exactly one pulse, from `SWTRIG`, not a spurious edge.
  - Write `SWTRIG` with `EN`=0 → no pulse.
- **Status and counter races:**
  - W1C of `STATUS`[0] coincident with a lo pulse → bit remains 1.
  - `EVT_CNT` write coincident with a pulse → reads 0.
  - Preload 0xFFFF lo events, then one more → lo count 0x0000.
- **Level mode and invalid select:**
  - `MODE`=11 with the line high for 10 cycles → 10 consecutive pulses, count +10.
  - `SEL`=0xFF → never fires except via `SWTRIG`.
